decode_ctrl_stage: RTL

//  Registered, parametrised RV32I decode/control stage: successor to the single-cycle opcode controller.

---
 rtl/decode_ctrl_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl_stage.sv
// RV32I decode/control stage: a small {pc,instr} queue feeding a registered
// decode bundle with valid/ready handshakes on both sides, plus synchronous flush.
module decode_ctrl_stage #(
    parameter int XLEN          = 32,
    parameter int QDEPTH        = 2,
    parameter int ENABLE_SYSTEM = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic            RegWrite,
    output logic            ALUSrc,
    output logic            MemWrite,
    output logic            MemRead,
    output logic            MemToReg,
    output logic            Branch,
    output logic            Link,
    output logic            BranchFromPC,
    output logic [1:0]      ALUOp,
    output logic            ALUSrcAPC,
    output logic            SysOp,
    output logic            Illegal
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // in_ready depends only on queue occupancy, never on out_ready.
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0] pc_mem_q    [QDEPTH];
    logic [31:0]     instr_mem_q [QDEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;

    logic            out_valid_q;
    logic [XLEN-1:0] out_pc_q;
    logic [4:0]      rd_q, rs1_q, rs2_q;
    logic [2:0]      funct3_q;
    logic            funct7b5_q;
    logic [12:0]     ctrl_q, ctrl_d;

    logic [31:0]     head_instr;
    logic [XLEN-1:0] head_pc;
    logic            push, load;
    logic            unused_head;

    assign head_instr  = instr_mem_q[rd_ptr_q];
    assign head_pc     = pc_mem_q[rd_ptr_q];
    assign unused_head = ^{head_instr[31], head_instr[29:25]};

    assign in_ready = (count_q < CW'(QDEPTH));
    assign push     = in_valid && in_ready && !flush;
    assign load     = (count_q != '0) && (!out_valid_q || out_ready) && !flush;
    assign count_d  = count_q + CW'(push) - CW'(load);

    logic       rw_d, src_d, mw_d, mr_d, m2r_d, br_d, lk_d, bpc_d, apc_d, sys_d, ill_d;
    logic [1:0] aop_d;

    always_comb begin
        rw_d  = 1'b0;
        src_d = 1'b0;
        mw_d  = 1'b0;
        mr_d  = 1'b0;
        m2r_d = 1'b0;
        br_d  = 1'b0;
        lk_d  = 1'b0;
        bpc_d = 1'b0;
        apc_d = 1'b0;
        sys_d = 1'b0;
        ill_d = 1'b0;
        aop_d = 2'b11;
        // Every listed opcode ends in 2'b11, so compressed encodings land in default.
        case (head_instr[6:0])
            7'b0110011: begin rw_d = 1'b1; aop_d = 2'b10; end
            7'b0010011: begin rw_d = 1'b1; src_d = 1'b1; aop_d = 2'b10; end
            7'b0110111: begin rw_d = 1'b1; src_d = 1'b1; aop_d = 2'b00; end
            7'b0010111: begin rw_d = 1'b1; src_d = 1'b1; apc_d = 1'b1; aop_d = 2'b00; end
            7'b0000011: begin
                rw_d = 1'b1; src_d = 1'b1; mr_d = 1'b1; m2r_d = 1'b1; aop_d = 2'b00;
            end
            7'b0100011: begin src_d = 1'b1; mw_d = 1'b1; aop_d = 2'b00; end
            7'b1100011: begin br_d = 1'b1; bpc_d = 1'b1; aop_d = 2'b01; end
            7'b1101111: begin rw_d = 1'b1; br_d = 1'b1; lk_d = 1'b1; bpc_d = 1'b1; end
            7'b1100111: begin rw_d = 1'b1; br_d = 1'b1; lk_d = 1'b1; end
            7'b0001111, 7'b1110011: begin
                if (ENABLE_SYSTEM != 0) sys_d = 1'b1;
                else                    ill_d = 1'b1;
            end
            default: ill_d = 1'b1;
        endcase
        if (head_instr[11:7] == 5'd0) rw_d = 1'b0;
    end

    assign ctrl_d = {rw_d, src_d, mw_d, mr_d, m2r_d, br_d, lk_d, bpc_d, aop_d, apc_d, sys_d, ill_d};

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            funct3_q    <= '0;
            funct7b5_q  <= 1'b0;
            ctrl_q      <= '0;
        end else if (flush) begin
            // Bundle fields are left as-is; consumers qualify them with out_valid.
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (load) begin
                rd_ptr_q    <= rd_ptr_q + PW'(1);
                out_valid_q <= 1'b1;
                out_pc_q    <= head_pc;
                rd_q        <= head_instr[11:7];
                rs1_q       <= head_instr[19:15];
                rs2_q       <= head_instr[24:20];
                funct3_q    <= head_instr[14:12];
                funct7b5_q  <= head_instr[30];
                ctrl_q      <= ctrl_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_rd       = rd_q;
    assign out_rs1      = rs1_q;
    assign out_rs2      = rs2_q;
    assign out_funct3   = funct3_q;
    assign out_funct7b5 = funct7b5_q;
    assign {RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch, Link, BranchFromPC,
            ALUOp, ALUSrcAPC, SysOp, Illegal} = ctrl_q;

endmodule
